// File: rtl/screen_writer.sv
`timescale 1ns/1ps
// screen_writer
// Upstream producer for the 80x25 character buffer RAM. Accepts a byte stream
// over a valid/ready handshake, maintains the cursor, writes printable
// characters and executes CR, LF, BS and FF. Scrolling rotates first_line for
// the video reader and then erases the new bottom row with FILL_CHAR writes.
//
// Handshake: a byte transfers on any rising clk edge where in_valid and
// in_ready are both 1. in_ready is high only in IDLE. The sender must hold
// in_data/in_valid stable while in_ready is low; nothing is dropped.
//
// Optional feature: define SCREEN_WRITER_TAB_EN to make 0x09 (HT) advance
// the cursor to the next multiple of 8 columns, clamped to COLS-1. Without
// it, 0x09 is consumed with no effect.
//
// dbg_state exposes the FSM state encoding (IDLE=0, CLEAR_LINE=1,
// CLEAR_ALL=2) for checkers.

module screen_writer #(
   parameter int          COLS      = 80,
   parameter int          ROWS      = 25,
   parameter int          ADDR_BITS = 11,
   parameter logic [7:0]  FILL_CHAR = 8'h20
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [7:0]           in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [ADDR_BITS-1:0] waddr,
   output logic [7:0]           wdata,
   output logic                 write_en,
   output logic [6:0]           cursor_col,
   output logic [4:0]           cursor_row,
   output logic [4:0]           first_line,
   output logic                 busy,
   output logic [1:0]           dbg_state
);

   localparam int CELLS = COLS * ROWS;
   localparam int CNT_W = (CELLS > 1) ? $clog2(CELLS) : 1;

   localparam logic [6:0] LAST_COL = 7'(COLS - 1);
   localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CLEAR_LINE = 2'd1,
      CLEAR_ALL  = 2'd2
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     erase_cnt;   // writes still to issue after the current one
   logic [ADDR_BITS-1:0] erase_addr;  // next address to erase

   logic                 accept;
   logic                 is_printable;
   logic [5:0]           row_sum;
   logic [4:0]           phys_row;
   logic [ADDR_BITS-1:0] cell_addr;
   logic [ADDR_BITS-1:0] old_row_addr;
   logic [4:0]           next_first_line;

   assign dbg_state = state;

   // Byte acceptance, logical-to-physical address mapping and scroll target
   always_comb begin
      accept          = in_valid & in_ready;
      is_printable    = (in_data >= 8'h20) && (in_data <= 8'h7E);
      row_sum         = {1'b0, first_line} + {1'b0, cursor_row};
      phys_row        = (row_sum >= 6'(ROWS)) ? 5'(row_sum - 6'(ROWS)) : row_sum[4:0];
      cell_addr       = ADDR_BITS'(phys_row) * ADDR_BITS'(COLS) + ADDR_BITS'(cursor_col);
      old_row_addr    = ADDR_BITS'(first_line) * ADDR_BITS'(COLS);
      next_first_line = (first_line == LAST_ROW) ? 5'd0 : first_line + 5'd1;
   end

`ifdef SCREEN_WRITER_TAB_EN
   logic [7:0] tab_next;
   logic [6:0] tab_col;

   // Next tab stop: round down to a multiple of 8, step one stop, clamp
   always_comb begin
      tab_next = {1'b0, cursor_col & 7'h78} + 8'd8;
      tab_col  = (tab_next > 8'(COLS - 1)) ? LAST_COL : tab_next[6:0];
   end
`endif

   // Control FSM: command decode, cursor/scroll state and registered write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         busy       <= 1'b0;
         write_en   <= 1'b0;
         waddr      <= '0;
         wdata      <= 8'h00;
         cursor_col <= 7'd0;
         cursor_row <= 5'd0;
         first_line <= 5'd0;
         erase_cnt  <= '0;
         erase_addr <= '0;
      end else begin
         write_en <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (is_printable) begin
                     write_en <= 1'b1;
                     waddr    <= cell_addr;
                     wdata    <= in_data;
                     // No autowrap: the last column is overwritten repeatedly
                     if (cursor_col != LAST_COL)
                        cursor_col <= cursor_col + 7'd1;
                  end else begin
                     case (in_data)
                        8'h0D: cursor_col <= 7'd0;
                        8'h0A: begin
                           if (cursor_row != LAST_ROW) begin
                              cursor_row <= cursor_row + 5'd1;
                           end else begin
                              // Scroll: the old top physical row becomes the
                              // new bottom row and is erased; first write now
                              first_line <= next_first_line;
                              write_en   <= 1'b1;
                              waddr      <= old_row_addr;
                              wdata      <= FILL_CHAR;
                              erase_addr <= old_row_addr + ADDR_BITS'(1);
                              erase_cnt  <= CNT_W'(COLS - 1);
                              state      <= CLEAR_LINE;
                              in_ready   <= 1'b0;
                              busy       <= 1'b1;
                           end
                        end
                        8'h08: begin
                           if (cursor_col != 7'd0)
                              cursor_col <= cursor_col - 7'd1;
                        end
                        8'h0C: begin
                           cursor_col <= 7'd0;
                           cursor_row <= 5'd0;
                           first_line <= 5'd0;
                           write_en   <= 1'b1;
                           waddr      <= '0;
                           wdata      <= FILL_CHAR;
                           erase_addr <= ADDR_BITS'(1);
                           erase_cnt  <= CNT_W'(CELLS - 1);
                           state      <= CLEAR_ALL;
                           in_ready   <= 1'b0;
                           busy       <= 1'b1;
                        end
`ifdef SCREEN_WRITER_TAB_EN
                        8'h09: cursor_col <= tab_col;
`endif
                        default: ;
                     endcase
                  end
               end
            end
            CLEAR_LINE, CLEAR_ALL: begin
               // Both erases share one ascending write sweep; only the
               // start address and length differ
               if (erase_cnt == '0) begin
                  state    <= IDLE;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
               end else begin
                  write_en   <= 1'b1;
                  waddr      <= erase_addr;
                  wdata      <= FILL_CHAR;
                  erase_addr <= erase_addr + ADDR_BITS'(1);
                  erase_cnt  <= erase_cnt - CNT_W'(1);
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
